cpu_fetch_mem_ctrl: RTL
=======================

# cpu_fetch_mem_ctrl

Parametrised fetch and memory-access controller for the simple RISC core. It owns the program counter, instruction register, data-address register and the single shared memory port. It fetches instructions over a variable-latency `mem_cmd`/`mem_ready` handshake and hands each instruction to the decoder/FSM. It also serves one load/store per request from the datapath and optionally applies PC-relative branches. It sits between the core FSM/datapath and the unified instruction/data memory.

## Interface
Parameters:
- `AW`, 9, memory address / PC width.
- `DW`, 16, instruction/data word width.
- `RESET_PC`, 0, PC value loaded on reset (truncated to AW).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_cmd` out 2: 00 NONE, 01 READ, 10 WRITE. Code 11 is never driven.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: write data, valid while `mem_cmd`=WRITE.
- `mem_rdata` in DW: read data, sampled when `mem_ready`=1.
- `mem_ready` in 1: memory completes the current command at this clock edge.
- `ir` out DW: instruction register.
- `ir_valid` out 1: one-cycle pulse when a new `ir` is loaded.
- `pc` out AW: address of the next instruction to fetch.
- `core_done` in 1: core finished the current instruction.
- `ls_req` in 1: load/store request from the core.
- `ls_write` in 1: 1 = store, 0 = load. Sampled with `ls_req`.
- `ls_addr` in DW: datapath result. Only the low AW bits are used.
- `ls_wdata` in DW: store data.
- `ls_rdata` out DW: load result register.
- `ls_done` out 1: one-cycle pulse when a load/store completes.
- `br_take` in 1: apply a branch with `core_done`.
- `br_offset` in DW: signed word offset, two's complement.
- `halt` in 1: stop fetching.
- `halted` out 1: controller is in the HALT state.

## Operation
- States: S_RESET, S_FETCH, S_EXEC, S_MEM, S_HALT. Encoding is free.
- Reset values: state=S_RESET, pc=RESET_PC, da=0, ir=0, ir_valid=0, ls_rdata=0, ls_done=0, halted=0. `mem_cmd`=NONE, `mem_wdata`=0.
- S_RESET: drives `mem_cmd`=NONE and `mem_addr`=pc. Next state is always S_FETCH.
- S_FETCH:
  - Drives `mem_cmd`=READ and `mem_addr`=pc.
  - On `mem_ready`: ir<=mem_rdata, pc<=pc+1, ir_valid<=1 for the next cycle, go to S_EXEC.
  - Otherwise hold the request.
- S_EXEC:
  - Drives `mem_cmd`=NONE and `mem_addr`=pc.
  - Priority: `halt` > `ls_req` > `core_done`.
  - `halt`: go to S_HALT.
  - `ls_req`: da<=ls_addr[AW-1:0], latch `ls_write` and `ls_wdata`, go to S_MEM.
  - `core_done`: go to S_FETCH. If a branch is enabled and `br_take`=1, pc<=pc+br_offset[AW-1:0]. The target is relative to the already-incremented PC.
- S_MEM:
  - Drives `mem_cmd`=WRITE (with `mem_wdata`=latched data) or READ, and `mem_addr`=da.
  - On `mem_ready`: for a load, ls_rdata<=mem_rdata. Pulse ls_done next cycle and go to S_EXEC.
- S_HALT: `mem_cmd`=NONE, `halted`=1. The only exit is `reset`.
- Arithmetic: all PC math is modulo 2^AW. pc=2^AW-1 increments to 0. Branch offset bits above AW are ignored.
- Simultaneous events:
  - `ls_req` together with `core_done`: the load/store is taken, and `core_done` is dropped. The core re-asserts it later.
  - `halt` in S_FETCH or S_MEM is ignored until S_EXEC. In-flight memory commands are never aborted.

## Timing
- `mem_cmd`, `mem_addr` and `mem_wdata` are functions of the registered state, pc, da and latched data only. They are stable for the whole command and change only after the edge where `mem_ready`=1.
- Zero-wait memory (`mem_ready` tied 1): a fetch takes 1 cycle in S_FETCH. `ir` and `ir_valid` are visible the cycle after.
- With N wait cycles, a fetch takes 1+N cycles. A load/store also takes 1+N cycles, with `ls_done` following.
- Minimum instruction loop with no load/store: S_FETCH → S_EXEC → S_FETCH, i.e. 2 cycles per instruction when `core_done` is asserted in the first S_EXEC cycle.
- `ir` holds its value through S_EXEC and S_MEM. It changes only on a fetch completion.
- Asynchronous reset: asserting `reset` mid-transaction forces `mem_cmd`=NONE immediately, without waiting for a clock edge. The first fetch from RESET_PC is issued 1 cycle after the first edge following deassertion.

## Configuration
- `CPU_FETCH_BRANCH_EN` defined: S_EXEC applies pc<=pc+br_offset when `core_done` and `br_take` are both 1.
- Not defined: `br_take` and `br_offset` are ignored (ports remain), and pc always advances sequentially.

## Test plan
- Reset, then `mem_ready`=1 with memory words 0x1111 at addr 0 and 0x2222 at addr 1, and `core_done` pulsed in each S_EXEC. Expect:
  - `ir`=0x1111 then 0x2222, one `ir_valid` pulse each.
  - READ at addresses 0 then 1, and `pc`=2.
- Fetch with `mem_ready` held low 3 cycles. Expect READ with a stable addr for 4 cycles, then `ir` loaded and exactly one `ir_valid` pulse.
- In S_EXEC, `ls_req`=1, `ls_write`=0, `ls_addr`=0xFE05 (AW=9 → addr 0x005), memory returns 0xABCD. Expect READ@0x005, `ls_rdata`=0xABCD, one `ls_done` pulse, return to S_EXEC.
- In S_EXEC, store `ls_wdata`=0x00FF to 0x010 while `core_done`=1 in the same cycle. Expect WRITE@0x010 with data 0x00FF, then S_EXEC with no fetch until `core_done` is re-asserted.
- With `CPU_FETCH_BRANCH_EN`: pc=0x1FF after fetch wrap, `br_take`=1, `br_offset`=0xFFFE. Expect next fetch addr 0x1FD. Without the macro, expect 0x1FF.
- Assert `halt` in S_EXEC, then assert `reset` mid-S_HALT. Expect `halted`=1 and `mem_cmd`=NONE, then a fetch at RESET_PC after reset deasserts.

Source files
------------

// File: rtl/cpu_fetch_mem_ctrl.sv
// Fetch / load-store controller owning pc, ir, data address and the shared memory port.
// Optional PC-relative branching is enabled by defining CPU_FETCH_BRANCH_EN.
module cpu_fetch_mem_ctrl #(
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    output logic [AW-1:0] pc,
    input  logic          core_done,
    input  logic          ls_req,
    input  logic          ls_write,
    input  logic [DW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    input  logic          br_take,
    input  logic [DW-1:0] br_offset,
    input  logic          halt,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [1:0]    CMD_NONE  = 2'b00;
    localparam logic [1:0]    CMD_READ  = 2'b01;
    localparam logic [1:0]    CMD_WRITE = 2'b10;
    localparam logic [AW-1:0] PC_INIT   = AW'(RESET_PC);

    state_t        state, state_next;
    logic [AW-1:0] da;
    logic          ls_wr_q;
    logic [DW-1:0] wdata_q;
    logic          fetch_ack, mem_ack, ls_take, done_take;

    assign fetch_ack = (state == S_FETCH) && mem_ready;
    assign mem_ack   = (state == S_MEM) && mem_ready;
    // halt outranks ls_req, which outranks core_done; a dropped core_done is re-asserted later
    assign ls_take   = (state == S_EXEC) && !halt && ls_req;
    assign done_take = (state == S_EXEC) && !halt && !ls_req && core_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: if (mem_ready) state_next = S_EXEC;
            S_EXEC: begin
                if (halt) begin
                    state_next = S_HALT;
                end else if (ls_req) begin
                    state_next = S_MEM;
                end else if (core_done) begin
                    state_next = S_FETCH;
                end
            end
            S_MEM:   if (mem_ready) state_next = S_EXEC;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // Port outputs depend only on registered state, so they stay stable for a whole command
    always_comb begin
        mem_cmd   = CMD_NONE;
        mem_addr  = pc;
        mem_wdata = '0;
        case (state)
            S_FETCH: mem_cmd = CMD_READ;
            S_MEM: begin
                mem_addr = da;
                if (ls_wr_q) begin
                    mem_cmd   = CMD_WRITE;
                    mem_wdata = wdata_q;
                end else begin
                    mem_cmd = CMD_READ;
                end
            end
            default: mem_cmd = CMD_NONE;
        endcase
    end

    assign halted = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_INIT;
            da       <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            ls_rdata <= '0;
            ls_done  <= 1'b0;
            ls_wr_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            ir_valid <= fetch_ack;
            ls_done  <= mem_ack;
            if (fetch_ack) begin
                ir <= mem_rdata;
                pc <= pc + AW'(1);
            end
            if (ls_take) begin
                da      <= ls_addr[AW-1:0];
                ls_wr_q <= ls_write;
                wdata_q <= ls_wdata;
            end
`ifdef CPU_FETCH_BRANCH_EN
            if (done_take && br_take) begin
                pc <= pc + br_offset[AW-1:0];
            end
`endif
            if (mem_ack && !ls_wr_q) begin
                ls_rdata <= mem_rdata;
            end
        end
    end

`ifdef CPU_FETCH_BRANCH_EN
    logic unused_bits;
    assign unused_bits = ^{ls_addr[DW-1:AW], br_offset[DW-1:AW]};
`else
    logic unused_bits;
    assign unused_bits = ^{ls_addr[DW-1:AW], br_take, br_offset, done_take};
`endif

endmodule
